// File: rtl/trap_pkg.sv
// Shared trap-controller definitions: FSM states, CSR bit
// positions, exception-vector indices and cause codes.
package trap_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_WAIT,
    S_REDIRECT
  } state_t;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MPP_LO   = 11;
  localparam int MPP_HI   = 12;

  localparam int MSIE_BIT = 3;
  localparam int MTIE_BIT = 7;
  localparam int MEIE_BIT = 11;

  localparam int EXC_EBREAK = 5;
  localparam int EXC_IMIS   = 4;
  localparam int EXC_ILL    = 3;
  localparam int EXC_ECALL  = 2;
  localparam int EXC_SMIS   = 1;
  localparam int EXC_LMIS   = 0;

  localparam logic [4:0] CAUSE_IMIS  = 5'd0;
  localparam logic [4:0] CAUSE_ILL   = 5'd2;
  localparam logic [4:0] CAUSE_BRK   = 5'd3;
  localparam logic [4:0] CAUSE_LMIS  = 5'd4;
  localparam logic [4:0] CAUSE_SMIS  = 5'd6;
  localparam logic [4:0] CAUSE_ECALL = 5'd11;
  localparam logic [4:0] CAUSE_MSI   = 5'd3;
  localparam logic [4:0] CAUSE_MTI   = 5'd7;
  localparam logic [4:0] CAUSE_MEI   = 5'd11;

  // {meip, mtip, msip} -> mip bits 11/7/3
  function automatic logic [11:0] irq_to_mip(
    input logic [2:0] irq
  );
    logic [11:0] m;
    m           = '0;
    m[MEIE_BIT] = irq[2];
    m[MTIE_BIT] = irq[1];
    m[MSIE_BIT] = irq[0];
    return m;
  endfunction

endpackage

// File: rtl/trap_prio.sv
// Combinational trap cause selection: interrupts first,
// then exceptions in architectural priority order.
module trap_prio
  import trap_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [5:0]      exc_i,
  input  logic [2:0]      irq_i,
  input  logic [2:0]      irq_en_i,
  input  logic            gie_i,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] badaddr_i,
  output logic            trap_o,
  output logic            is_int_o,
  output logic [XLEN-1:0] cause_o,
  output logic [XLEN-1:0] tval_o
);

  logic [2:0] w_pend;
  logic [4:0] w_code;

  always_comb begin
    w_pend   = irq_i & irq_en_i & {3{gie_i}};
    w_code   = '0;
    tval_o   = '0;
    is_int_o = |w_pend;
    trap_o   = is_int_o | (|exc_i);
    if (w_pend[2]) begin
      w_code = CAUSE_MEI;
    end else if (w_pend[0]) begin
      w_code = CAUSE_MSI;
    end else if (w_pend[1]) begin
      w_code = CAUSE_MTI;
    end else if (exc_i[EXC_EBREAK]) begin
      w_code = CAUSE_BRK;
    end else if (exc_i[EXC_IMIS]) begin
      w_code = CAUSE_IMIS;
      tval_o = badaddr_i;
    end else if (exc_i[EXC_ILL]) begin
      w_code = CAUSE_ILL;
      tval_o = XLEN'(inst_i);
    end else if (exc_i[EXC_ECALL]) begin
      w_code = CAUSE_ECALL;
    end else if (exc_i[EXC_SMIS]) begin
      w_code = CAUSE_SMIS;
      tval_o = badaddr_i;
    end else if (exc_i[EXC_LMIS]) begin
      w_code = CAUSE_LMIS;
      tval_o = badaddr_i;
    end
    cause_o         = '0;
    cause_o[4:0]    = w_code;
    cause_o[XLEN-1] = is_int_o;
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap/MRET sequencer: captures CSR write data,
// stalls the pipeline, then flushes and redirects fetch.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int TRAP_LAT = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] badaddr_i,
  input  logic [5:0]      exc_i,
  input  logic            mret_i,
  input  logic [2:0]      irq_i,
  input  logic [XLEN-1:0] mie_i,
  input  logic [XLEN-1:0] mstatus_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  output logic            stall_o,
  output logic            flush_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] pc_target_o,
  output logic            we_exc_o,
  output logic [XLEN-1:0] mcause_o,
  output logic [XLEN-1:0] mepc_o,
  output logic [XLEN-1:0] mtval_o,
  output logic [XLEN-1:0] mstatus_o,
  output logic [XLEN-1:0] mip_o,
  output logic            is_int_o
);

  localparam logic [1:0] LAT_M1 =
    (TRAP_LAT > 0) ? 2'(TRAP_LAT - 1) : 2'd0;

  state_t          r_state, w_next;
  logic [1:0]      r_cnt;
  logic [XLEN-1:0] r_cause, r_epc, r_tval;
  logic [XLEN-1:0] r_status, r_mip;
  logic            r_is_int, r_mret;

  logic            w_trap, w_is_int;
  logic            w_take, w_ret;
  logic [XLEN-1:0] w_cause, w_tval;
  logic [XLEN-1:0] w_trap_st, w_ret_st;
  logic            w_unused;

  assign w_unused = ^{mie_i, mtvec_i[1:0], pc_i[0]};

  trap_prio #(.XLEN(XLEN)) u_prio (
    .exc_i     (exc_i),
    .irq_i     (irq_i),
    .irq_en_i  ({mie_i[MEIE_BIT], mie_i[MTIE_BIT],
                 mie_i[MSIE_BIT]}),
    .gie_i     (mstatus_i[MIE_BIT]),
    .inst_i    (inst_i),
    .badaddr_i (badaddr_i),
    .trap_o    (w_trap),
    .is_int_o  (w_is_int),
    .cause_o   (w_cause),
    .tval_o    (w_tval)
  );

  assign w_take = valid_i & w_trap;
  assign w_ret  = valid_i & mret_i & ~w_trap;

  always_comb begin
    w_trap_st                 = mstatus_i;
    w_trap_st[MPIE_BIT]       = mstatus_i[MIE_BIT];
    w_trap_st[MIE_BIT]        = 1'b0;
    w_trap_st[MPP_HI:MPP_LO]  = 2'b11;
    w_ret_st                  = mstatus_i;
    w_ret_st[MIE_BIT]         = mstatus_i[MPIE_BIT];
    w_ret_st[MPIE_BIT]        = 1'b1;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_take || w_ret) w_next = S_WRITE;
      S_WRITE:
        w_next = (TRAP_LAT == 0) ? S_REDIRECT : S_WAIT;
      S_WAIT:
        if (r_cnt == 2'd0) w_next = S_REDIRECT;
      S_REDIRECT:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_cause  <= '0;
      r_epc    <= '0;
      r_tval   <= '0;
      r_status <= '0;
      r_mip    <= '0;
      r_is_int <= 1'b0;
      r_mret   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_mip   <= XLEN'(irq_to_mip(irq_i));
      if (r_state == S_IDLE && w_take) begin
        r_cause  <= w_cause;
        r_epc    <= {pc_i[XLEN-1:1], 1'b0};
        r_tval   <= w_tval;
        r_status <= w_trap_st;
        r_is_int <= w_is_int;
        r_mret   <= 1'b0;
      end else if (r_state == S_IDLE && w_ret) begin
        // MRET leaves mcause/mtval as they were
        r_epc    <= mepc_i;
        r_status <= w_ret_st;
        r_is_int <= 1'b0;
        r_mret   <= 1'b1;
      end
      if (r_state == S_WRITE) begin
        r_cnt <= LAT_M1;
      end else if (r_state == S_WAIT && r_cnt != 2'd0) begin
        r_cnt <= r_cnt - 2'd1;
      end
    end
  end

  assign stall_o    = (r_state != S_IDLE);
  assign we_exc_o   = (r_state == S_WRITE);
  assign redirect_o = (r_state == S_REDIRECT);
  assign flush_o    = (r_state == S_REDIRECT);
  assign pc_target_o = !redirect_o ? '0 :
                       r_mret ? mepc_i :
                       {mtvec_i[XLEN-1:2], 2'b00};
  assign mcause_o   = r_cause;
  assign mepc_o     = r_epc;
  assign mtval_o    = r_tval;
  assign mstatus_o  = r_status;
  assign mip_o      = r_mip;
  assign is_int_o   = r_is_int;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed vector bench for trap_ctrl: table of trap cases
// plus hand sequences for MRET and reset corner cases.
module tb_trap_ctrl;

  localparam int XLEN = 32;
  localparam int LAT  = 1;
  localparam logic [31:0] MTVEC = 32'h8000_0105;
  localparam logic [31:0] VEC   = 32'h8000_0104;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [31:0] pc_i, inst_i, badaddr_i;
  logic [5:0]  exc_i;
  logic        mret_i;
  logic [2:0]  irq_i;
  logic [31:0] mie_i, mstatus_i, mtvec_i, mepc_i;
  logic        stall_o, flush_o, redirect_o, we_exc_o, is_int_o;
  logic [31:0] pc_target_o, mcause_o, mepc_o, mtval_o;
  logic [31:0] mstatus_o, mip_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  trap_ctrl #(.XLEN(XLEN), .TRAP_LAT(LAT)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .pc_i        (pc_i),
    .inst_i      (inst_i),
    .badaddr_i   (badaddr_i),
    .exc_i       (exc_i),
    .mret_i      (mret_i),
    .irq_i       (irq_i),
    .mie_i       (mie_i),
    .mstatus_i   (mstatus_i),
    .mtvec_i     (mtvec_i),
    .mepc_i      (mepc_i),
    .stall_o     (stall_o),
    .flush_o     (flush_o),
    .redirect_o  (redirect_o),
    .pc_target_o (pc_target_o),
    .we_exc_o    (we_exc_o),
    .mcause_o    (mcause_o),
    .mepc_o      (mepc_o),
    .mtval_o     (mtval_o),
    .mstatus_o   (mstatus_o),
    .mip_o       (mip_o),
    .is_int_o    (is_int_o)
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc, inst, bad;
    logic [5:0]  exc;
    logic        mret;
    logic [2:0]  irq;
    logic [31:0] mie, mst;
    logic        take;
    logic [31:0] cause, epc, tval, st, mip;
    logic        isint;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(
    input logic v, input logic [31:0] pc, inst, bad,
    input logic [5:0] exc, input logic mret,
    input logic [2:0] irq, input logic [31:0] mie, mst,
    input logic take, input logic [31:0] cause, epc,
    input logic [31:0] tval, st, mip, input logic isint
  );
    vec_t r;
    r.valid = v;   r.pc = pc;     r.inst = inst;
    r.bad = bad;   r.exc = exc;   r.mret = mret;
    r.irq = irq;   r.mie = mie;   r.mst = mst;
    r.take = take; r.cause = cause; r.epc = epc;
    r.tval = tval; r.st = st;     r.mip = mip;
    r.isint = isint;
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    valid_i = 0; exc_i = '0; mret_i = 0; irq_i = '0;
    pc_i = '0; inst_i = '0; badaddr_i = '0;
    mie_i = '0; mstatus_i = '0;
  endtask

  task automatic wait_redirect(input logic [31:0] tgt,
                               input string nm);
    int n;
    n = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_i);
      if (redirect_o) begin
        n = k;
        break;
      end
    end
    chk({nm, " redirect_lat"}, 32'(n), 32'(1 + LAT));
    chk({nm, " pc_target"}, pc_target_o, tgt);
    chk({nm, " flush"}, 32'(flush_o), 32'd1);
    @(negedge clk_i);
    chk({nm, " back_idle"}, 32'({stall_o, redirect_o}), 32'd0);
  endtask

  initial begin
    mtvec_i = MTVEC;
    mepc_i  = 32'h0000_0400;
    idle_inputs();
    rst_i = 0;

    tbl[0]  = mk(1, 32'h100, 32'hFFFF_FFFF, 32'h55,
                 6'b001000, 0, 3'b000, 32'h0, 32'h0,
                 1, 32'd2, 32'h100, 32'hFFFF_FFFF,
                 32'h1800, 32'h0, 0);
    tbl[1]  = mk(1, 32'h204, 32'h0, 32'h0,
                 6'b000000, 0, 3'b110, 32'h880, 32'h8,
                 1, 32'h8000_000B, 32'h204, 32'h0,
                 32'h1880, 32'h880, 1);
    tbl[2]  = mk(1, 32'h300, 32'h0, 32'h203,
                 6'b100001, 0, 3'b000, 32'h0, 32'h0,
                 1, 32'd3, 32'h300, 32'h0,
                 32'h1800, 32'h0, 0);
    tbl[3]  = mk(1, 32'h103, 32'h1234, 32'h103,
                 6'b011000, 0, 3'b000, 32'h0, 32'h0,
                 1, 32'd0, 32'h102, 32'h103,
                 32'h1800, 32'h0, 0);
    tbl[4]  = mk(1, 32'h500, 32'h0, 32'h7FF1,
                 6'b000011, 0, 3'b000, 32'h0, 32'h0,
                 1, 32'd6, 32'h500, 32'h7FF1,
                 32'h1800, 32'h0, 0);
    tbl[5]  = mk(1, 32'h600, 32'h0, 32'h12,
                 6'b000001, 0, 3'b000, 32'h0, 32'h88,
                 1, 32'd4, 32'h600, 32'h12,
                 32'h1880, 32'h0, 0);
    tbl[6]  = mk(1, 32'h700, 32'h0, 32'h44,
                 6'b000110, 0, 3'b000, 32'h0, 32'h1808,
                 1, 32'd11, 32'h700, 32'h0,
                 32'h1880, 32'h0, 0);
    tbl[7]  = mk(1, 32'h800, 32'hDEAD, 32'h0,
                 6'b001000, 0, 3'b011, 32'h88, 32'h8,
                 1, 32'h8000_0003, 32'h800, 32'h0,
                 32'h1880, 32'h88, 1);
    tbl[8]  = mk(1, 32'h900, 32'h0, 32'h0,
                 6'b000000, 0, 3'b010, 32'h888, 32'h8,
                 1, 32'h8000_0007, 32'h900, 32'h0,
                 32'h1880, 32'h80, 1);
    tbl[9]  = mk(1, 32'hA00, 32'h0, 32'h0,
                 6'b000100, 0, 3'b100, 32'h080, 32'h8,
                 1, 32'd11, 32'hA00, 32'h0,
                 32'h1880, 32'h800, 0);
    tbl[10] = mk(1, 32'hB00, 32'h0, 32'h0,
                 6'b000100, 1, 3'b000, 32'h0, 32'h8,
                 1, 32'd11, 32'hB00, 32'h0,
                 32'h1880, 32'h0, 0);
    tbl[11] = mk(0, 32'hC00, 32'h0, 32'h0,
                 6'b000000, 0, 3'b100, 32'h800, 32'h8,
                 0, 32'h0, 32'h0, 32'h0,
                 32'h0, 32'h800, 0);
    tbl[12] = mk(1, 32'hD00, 32'h0, 32'h0,
                 6'b000000, 0, 3'b111, 32'h888, 32'h0,
                 0, 32'h0, 32'h0, 32'h0,
                 32'h0, 32'h888, 0);

    repeat (2) @(negedge clk_i);
    chk("rst stall", 32'(stall_o), 32'd0);
    chk("rst we_exc", 32'(we_exc_o), 32'd0);
    chk("rst redirect", 32'(redirect_o), 32'd0);
    chk("rst mcause", mcause_o, 32'd0);
    chk("rst mstatus", mstatus_o, 32'd0);
    rst_i = 1;
    @(negedge clk_i);

    foreach (tbl[i]) begin
      string nm;
      nm = $sformatf("v%0d", i);
      valid_i = tbl[i].valid; pc_i = tbl[i].pc;
      inst_i = tbl[i].inst;   badaddr_i = tbl[i].bad;
      exc_i = tbl[i].exc;     mret_i = tbl[i].mret;
      irq_i = tbl[i].irq;     mie_i = tbl[i].mie;
      mstatus_i = tbl[i].mst;
      @(negedge clk_i);
      valid_i = 0;
      chk({nm, " mip"}, mip_o, tbl[i].mip);
      chk({nm, " we_exc"}, 32'(we_exc_o), 32'(tbl[i].take));
      chk({nm, " stall"}, 32'(stall_o), 32'(tbl[i].take));
      if (tbl[i].take) begin
        chk({nm, " mcause"}, mcause_o, tbl[i].cause);
        chk({nm, " mepc"}, mepc_o, tbl[i].epc);
        chk({nm, " mtval"}, mtval_o, tbl[i].tval);
        chk({nm, " mstatus"}, mstatus_o, tbl[i].st);
        chk({nm, " is_int"}, 32'(is_int_o),
            32'(tbl[i].isint));
        wait_redirect(VEC, nm);
      end
      idle_inputs();
      @(negedge clk_i);
    end

    // MRET: cause/tval keep the last trap's values
    valid_i = 1; mret_i = 1; mstatus_i = 32'h80;
    @(negedge clk_i);
    valid_i = 0; mret_i = 0;
    chk("mret we_exc", 32'(we_exc_o), 32'd1);
    chk("mret mstatus", mstatus_o, 32'h88);
    chk("mret mepc", mepc_o, 32'h400);
    chk("mret mcause", mcause_o, 32'd11);
    chk("mret is_int", 32'(is_int_o), 32'd0);
    wait_redirect(32'h400, "mret");
    idle_inputs();

    // reset while in WAIT abandons the trap
    valid_i = 1; exc_i = 6'b001000; pc_i = 32'h140;
    @(negedge clk_i);
    idle_inputs();
    chk("rw we_exc", 32'(we_exc_o), 32'd1);
    @(negedge clk_i);
    chk("rw in_wait", 32'({stall_o, we_exc_o}), 32'd2);
    rst_i = 0;
    @(negedge clk_i);
    rst_i = 1;
    chk("rw stall", 32'(stall_o), 32'd0);
    chk("rw mcause", mcause_o, 32'd0);
    chk("rw mepc", mepc_o, 32'd0);
    begin
      int seen;
      seen = 0;
      repeat (4) begin
        @(negedge clk_i);
        if (redirect_o || stall_o) seen++;
      end
      chk("rw no_redirect", 32'(seen), 32'd0);
    end

    // reset beats a trap presented in the same cycle
    valid_i = 1; exc_i = 6'b000100; rst_i = 0;
    @(negedge clk_i);
    chk("rp stall", 32'(stall_o), 32'd0);
    chk("rp we_exc", 32'(we_exc_o), 32'd0);
    rst_i = 1;
    idle_inputs();
    @(negedge clk_i);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter TRAP_LAT, default 1, extra stall cycles between CSR write and redirect (range 0..3).
REQ-003 SHALL have port clk_i  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port valid_i  in  1  commit-stage instruction valid.
REQ-006 SHALL have port pc_i  in  XLEN  PC of committing instruction.
REQ-007 SHALL have port inst_i  in  32  committing instruction word.
REQ-008 SHALL have port badaddr_i  in  XLEN  faulting address.
REQ-009 SHALL have port exc_i  in  6  {ebreak, inst_misalign, illegal, ecall, store_misalign, load_misalign}, bit5..bit0.
REQ-010 SHALL have port mret_i  in  1  committing MRET.
REQ-011 SHALL have port irq_i  in  3  {meip, mtip, msip}.
REQ-012 SHALL have ports mie_i, mstatus_i, mtvec_i, mepc_i  in  XLEN  current CSR values.
REQ-013 SHALL have port stall_o  out  1  freeze pipeline.
REQ-014 SHALL have port flush_o  out  1  kill younger instructions.
REQ-015 SHALL have port redirect_o  out  1  load pc_target_o into fetch.
REQ-016 SHALL have port pc_target_o  out  XLEN  redirect address.
REQ-017 SHALL have port we_exc_o  out  1  CSR trap-write strobe.
REQ-018 SHALL have ports mcause_o, mepc_o, mtval_o, mstatus_o, mip_o  out  XLEN  CSR write data.
REQ-019 SHALL have port is_int_o  out  1  current trap is an interrupt.

Function
REQ-020 FSM states SHALL be IDLE, WRITE, WAIT, REDIRECT.
REQ-021 In IDLE, a trap SHALL be taken when valid_i=1 and (any exc_i bit set or an interrupt is enabled-pending); transition to WRITE next edge.
REQ-022 Enabled-pending SHALL be irq_i[k] & mie_i[{11,7,3}[k]] & mstatus_i[3].
REQ-023 Interrupts SHALL win over exceptions; priority MEI(0x8000000B) > MSI(0x80000003) > MTI(0x80000007).
REQ-024 Exception priority SHALL be ebreak(3) > inst_misalign(0) > illegal(2) > ecall(11) > store_misalign(6) > load_misalign(4).
REQ-025 mtval_o SHALL be badaddr_i for misaligned causes, inst_i for illegal, 0 otherwise; mepc_o SHALL be pc_i with bit0 cleared.
REQ-026 mstatus_o on trap SHALL be mstatus_i with MPIE(7)<=MIE(3), MIE<=0, MPP(12:11)<=2'b11.
REQ-027 In WRITE, we_exc_o SHALL be 1 for exactly one cycle with registered cause/epc/tval/status; is_int_o valid same cycle.
REQ-028 WAIT SHALL last TRAP_LAT cycles (skipped if 0), then REDIRECT.
REQ-029 In REDIRECT, redirect_o and flush_o SHALL be 1 for one cycle, pc_target_o=mtvec_i with bits1:0 cleared; return to IDLE.
REQ-030 MRET in IDLE (valid_i=1, no exception/interrupt) SHALL go to WRITE with mstatus_o MIE<=MPIE, MPIE<=1, we_exc_o=1, mcause/mtval/mepc unchanged (mepc_o=mepc_i), then redirect to mepc_i.
REQ-031 Exception and mret_i together SHALL take the exception.
REQ-032 stall_o SHALL be 1 in every non-IDLE state; inputs other than CSR values SHALL be ignored outside IDLE.
REQ-033 mip_o SHALL be irq_i mapped to bits 11/7/3, registered every cycle regardless of state.
REQ-034 valid_i=0 SHALL never start a trap even with pending interrupts.

Reset
REQ-035 rst_i=0 at an edge SHALL force IDLE and all outputs to 0, including mid-trap (no partial CSR write after reset).
REQ-036 Reset SHALL take priority over every other event in the same cycle.

Structure
REQ-037 Cause codes, mstatus/mie bit positions and the FSM state enum SHALL live in shared package trap_pkg.
REQ-038 Cause/priority selection SHALL be a combinational sub-module trap_prio; FSM and output registers SHALL reside in trap_ctrl.

Verification
REQ-039 pc_i=0x100, exc_i=illegal, inst_i=0xFFFFFFFF -> WRITE: mcause=2, mepc=0x100, mtval=0xFFFFFFFF; REDIRECT to mtvec_i&~3 after 1+TRAP_LAT cycles.
REQ-040 mstatus_i=0x8, mie_i=0x880, irq_i=3'b110 -> mcause=0x8000000B, is_int_o=1, mstatus_o=0x1880.
REQ-041 exc_i=ebreak|load_misalign, badaddr_i=0x203 -> mcause=3, mtval=0.
REQ-042 mret_i=1, mstatus_i=0x80, mepc_i=0x400 -> mstatus_o=0x88, redirect to 0x400.
REQ-043 rst_i=0 during WAIT -> next cycle IDLE, stall_o=0, no redirect_o; irq pending with mstatus_i[3]=0 -> no trap.
